gayle_bus_master: RTL and testbench

//  Initiator side of the Gayle register bus. Turns single-beat commands (register read,

---
 rtl/gayle_bus_master.sv | 169 ++++++++++++++++
 tb/tb_gayle_bus_master.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gayle_bus_master.sv
// Gayle register-bus initiator: read/write/ID-probe commands become CS/DS/RW/A bus cycles.
// RSP_VALID rises 1+S+R cycles after accept (probe 5*(1+S+R), reserved op next cycle); CMD_READY only in IDLE.
module gayle_bus_master #(
    parameter int         STROBE_CYCLES   = 2,
    parameter int         RECOVERY_CYCLES = 1,
    parameter logic [3:0] EXPECT_ID       = 4'hd
) (
    input  logic       i_clkcpu,
    input  logic       i_reset,
    input  logic       i_cmd_valid,
    output logic       o_cmd_ready,
    input  logic [1:0] i_cmd_op,
    input  logic [3:0] i_cmd_addr,
    input  logic [7:0] i_cmd_wdata,
    output logic       o_rsp_valid,
    output logic [7:0] o_rsp_rdata,
    output logic       o_rsp_err,
    output logic [3:0] o_id_val,
    output logic       o_id_ok,
    output logic       o_cs,
    output logic       o_ds,
    output logic       o_rw,
    output logic       o_a18,
    output logic [2:0] o_a,
    output logic [7:0] o_dout,
    input  logic [7:0] i_din
);
    localparam int S_EFF   = (STROBE_CYCLES < 2) ? 2 : STROBE_CYCLES;
    localparam int R_EFF   = (RECOVERY_CYCLES < 1) ? 1 : RECOVERY_CYCLES;
    localparam int CNT_MAX = (S_EFF > R_EFF) ? S_EFF : R_EFF;
    localparam int CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] S_LAST = CW'(S_EFF - 1);
    localparam logic [CW-1:0] R_LAST = CW'(R_EFF - 1);
    localparam logic [1:0] OP_RD = 2'b00;
    localparam logic [1:0] OP_WR = 2'b01;
    localparam logic [1:0] OP_ID = 2'b10;
    localparam logic [3:0] ID_ADDR = 4'h9;

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, RECOVER, DONE} state_t;

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_op;
    logic [2:0]    r_beat;
    logic [7:0]    r_rdbuf;
    logic          r_rsp_valid;
    logic [7:0]    r_rsp_rdata;
    logic          r_rsp_err;
    logic [3:0]    r_id_val;
    logic          r_id_ok;
    logic          r_cs;
    logic          r_ds;
    logic          r_rw;
    logic          r_a18;
    logic [2:0]    r_a;
    logic [7:0]    r_dout;

    assign o_cmd_ready = (r_state == IDLE);
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;
    assign o_rsp_err   = r_rsp_err;
    assign o_id_val    = r_id_val;
    assign o_id_ok     = r_id_ok;
    assign o_cs        = r_cs;
    assign o_ds        = r_ds;
    assign o_rw        = r_rw;
    assign o_a18       = r_a18;
    assign o_a         = r_a;
    assign o_dout      = r_dout;

    always_ff @(posedge i_clkcpu or negedge i_reset) begin
        if (!i_reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_op        <= 2'b00;
            r_beat      <= 3'd0;
            r_rdbuf     <= 8'h00;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 8'h00;
            r_rsp_err   <= 1'b0;
            r_id_val    <= 4'h0;
            r_id_ok     <= 1'b0;
            r_cs        <= 1'b1;
            r_ds        <= 1'b1;
            r_rw        <= 1'b1;
            r_a18       <= 1'b0;
            r_a         <= 3'd0;
            r_dout      <= 8'h00;
        end else begin
            r_rsp_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_cmd_valid) begin
                        r_op   <= i_cmd_op;
                        r_beat <= 3'd0;
                        if (i_cmd_op == 2'b11) begin
                            r_state     <= DONE;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else begin
                            r_state <= SETUP;
                            r_cs    <= 1'b0;
                            if (i_cmd_op == OP_ID) begin
                                // Probe opens with a write that rewinds the responder's ID shifter.
                                {r_a18, r_a} <= ID_ADDR;
                                r_rw         <= 1'b0;
                                r_dout       <= 8'h00;
                                r_id_val     <= 4'h0;
                            end else begin
                                {r_a18, r_a} <= i_cmd_addr;
                                r_rw         <= (i_cmd_op == OP_RD);
                                if (i_cmd_op == OP_WR) begin
                                    r_dout <= i_cmd_wdata;
                                end
                            end
                        end
                    end
                end
                SETUP: begin
                    r_state <= STROBE;
                    r_ds    <= 1'b0;
                    r_cnt   <= S_LAST;
                end
                STROBE: begin
                    if (r_cnt == '0) begin
                        r_state <= RECOVER;
                        r_cs    <= 1'b1;
                        r_ds    <= 1'b1;
                        r_rw    <= 1'b1;
                        r_cnt   <= R_LAST;
                        r_rdbuf <= i_din;
                        if (r_op == OP_ID && r_beat != 3'd0) begin
                            r_id_val <= {r_id_val[2:0], i_din[7]};
                        end
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                RECOVER: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else if (r_op == OP_ID && r_beat != 3'd4) begin
                        r_beat  <= r_beat + 3'd1;
                        r_state <= SETUP;
                        r_cs    <= 1'b0;
                        r_rw    <= 1'b1;
                    end else begin
                        r_state     <= DONE;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        if (r_op == OP_RD) begin
                            r_rsp_rdata <= r_rdbuf;
                        end else if (r_op == OP_ID) begin
                            r_id_ok     <= (r_id_val == EXPECT_ID);
                            r_rsp_rdata <= {4'h0, r_id_val};
                            r_rsp_err   <= (r_id_val != EXPECT_ID);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_gayle_bus_master.sv
// Bench for gayle_bus_master: responder model, command-level reference model, per-cycle compare.
module tb_gayle_bus_master;
    localparam int         S      = 2;
    localparam int         R      = 1;
    localparam logic [3:0] EXP_ID = 4'hd;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_cmd_valid = 1'b0;
    logic [1:0] i_cmd_op = 2'b00;
    logic [3:0] i_cmd_addr = 4'h0;
    logic [7:0] i_cmd_wdata = 8'h00;
    logic [7:0] din = 8'h00;
    logic       o_cmd_ready, o_rsp_valid, o_rsp_err, o_id_ok;
    logic [7:0] o_rsp_rdata, o_dout;
    logic [3:0] o_id_val;
    logic       o_cs, o_ds, o_rw, o_a18;
    logic [2:0] o_a;

    always #5 clk = ~clk;

    gayle_bus_master #(.STROBE_CYCLES(S), .RECOVERY_CYCLES(R), .EXPECT_ID(EXP_ID)) dut (
        .i_clkcpu(clk), .i_reset(rst_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op),
        .i_cmd_addr(i_cmd_addr), .i_cmd_wdata(i_cmd_wdata),
        .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_id_val(o_id_val), .o_id_ok(o_id_ok),
        .o_cs(o_cs), .o_ds(o_ds), .o_rw(o_rw), .o_a18(o_a18), .o_a(o_a),
        .o_dout(o_dout), .i_din(din)
    );

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: acts on the first edge that sees DS low; address 9 is the ID shifter.
    logic [7:0] rmem [16];
    logic [3:0] resp_id = 4'hd;
    int         rid_idx = 0;
    bit         tie0 = 1'b0;
    logic       ds_q = 1'b1;

    always @(posedge clk) begin
        logic [7:0] v;
        ds_q <= o_ds;
        if (!o_ds && ds_q && !o_cs) begin
            if (o_rw) begin
                if ({o_a18, o_a} == 4'h9) begin
                    v = (rid_idx < 4) ? {resp_id[3 - rid_idx], 7'b0} : 8'h00;
                    rid_idx <= rid_idx + 1;
                end else begin
                    v = rmem[{o_a18, o_a}];
                end
                din <= tie0 ? 8'h00 : v;
            end else if ({o_a18, o_a} == 4'h9) begin
                rid_idx <= 0;
            end else begin
                rmem[{o_a18, o_a}] <= o_dout;
            end
        end
    end

    // Command-level reference model.
    logic [7:0] shadow [16];
    bit         pend = 1'b0;
    int         pend_due = 0;
    logic [1:0] pend_op = 2'b00;
    logic [3:0] pend_addr = 4'h0;
    logic [7:0] pend_wdata = 8'h00;
    logic [7:0] pend_rdata = 8'h00;
    bit         pend_err = 1'b0;
    logic [3:0] pend_id = 4'h0;
    int         pend_beats = 0;
    logic [7:0] m_rdata = 8'h00;
    logic [3:0] m_id = 4'h0;
    bit         m_ok = 1'b0;

    int         dslow = 0, cslow = 0, dshigh = 0, bus_beat = 0;
    bit         had_strobe = 1'b0;
    logic       ds_p = 1'b1, cs_p = 1'b1;
    logic [3:0] exp_addr;
    logic       exp_rw;

    always @(negedge clk) begin
        if (!rst_n) begin
            pend = 1'b0; m_rdata = 8'h00; m_id = 4'h0; m_ok = 1'b0;
            dslow = 0; cslow = 0; dshigh = 0; bus_beat = 0; had_strobe = 1'b0;
            ds_p = 1'b1; cs_p = 1'b1;
            chk("reset cs", o_cs, 1);
            chk("reset ds", o_ds, 1);
            chk("reset rw", o_rw, 1);
            chk("reset addr", {o_a18, o_a}, 0);
            chk("reset dout", o_dout, 0);
            chk("reset rsp_valid", o_rsp_valid, 0);
            chk("reset rsp_rdata", o_rsp_rdata, 0);
            chk("reset rsp_err", o_rsp_err, 0);
            chk("reset id_val", o_id_val, 0);
            chk("reset id_ok", o_id_ok, 0);
            chk("reset cmd_ready", o_cmd_ready, 1);
        end else begin
            if (!o_ds) begin
                if (ds_p) begin
                    chk("cs low at strobe start", o_cs, 0);
                    if (had_strobe) begin
                        checks++;
                        if (dshigh < R + 1) begin
                            errors++;
                            $display("FAIL ds_gap: %0d high cycles between strobes, need >= %0d", dshigh, R + 1);
                        end
                    end
                end
                dslow++;
                exp_addr = (pend_op == 2'b10) ? 4'h9 : pend_addr;
                exp_rw   = (pend_op == 2'b10) ? (bus_beat != 0) : (pend_op == 2'b00);
                chk("strobe addr", {o_a18, o_a}, exp_addr);
                chk("strobe rw", o_rw, exp_rw);
                if (!exp_rw) chk("strobe dout", o_dout, (pend_op == 2'b10) ? 8'h00 : pend_wdata);
            end else begin
                if (!ds_p) begin
                    chk("ds low width", dslow, S);
                    dslow = 0; dshigh = 0; had_strobe = 1'b1; bus_beat++;
                end
                dshigh++;
            end
            if (!o_cs) cslow++;
            else if (!cs_p) begin
                chk("cs low width", cslow, S + 1);
                cslow = 0;
            end
            ds_p = o_ds; cs_p = o_cs;

            if (pend && cyc == pend_due) begin
                chk("rsp_valid at due cycle", o_rsp_valid, 1);
                chk("rsp_rdata", o_rsp_rdata, pend_rdata);
                chk("rsp_err", o_rsp_err, pend_err);
                chk("bus accesses per command", bus_beat, pend_beats);
                chk("cmd_ready in done", o_cmd_ready, 0);
                if (pend_op == 2'b10) begin
                    chk("probe id_val", o_id_val, pend_id);
                    chk("probe id_ok", o_id_ok, pend_id == EXP_ID);
                    m_id = pend_id; m_ok = (pend_id == EXP_ID);
                end
                m_rdata = pend_rdata; pend = 1'b0; bus_beat = 0;
            end else begin
                chk("rsp_valid idle", o_rsp_valid, 0);
                chk("rsp_rdata held", o_rsp_rdata, m_rdata);
                chk("cmd_ready", o_cmd_ready, !pend);
                if (!(pend && pend_op == 2'b10)) begin
                    chk("id_val held", o_id_val, m_id);
                    chk("id_ok held", o_id_ok, m_ok);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [3:0] addr, input logic [7:0] wd);
        int  acc;
        int  lat;
        bit  rdy;
        logic [3:0] idv;
        @(negedge clk);
        i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_addr = addr; i_cmd_wdata = wd;
        acc = -1;
        for (int k = 0; k < 200 && acc < 0; k++) begin
            rdy = o_cmd_ready;
            @(posedge clk); #1;
            if (rdy) acc = cyc;
        end
        i_cmd_valid = 1'b0;
        i_cmd_op = 2'($urandom); i_cmd_addr = 4'($urandom); i_cmd_wdata = 8'($urandom);
        if (acc < 0) begin
            chk("accept timeout", 0, 1);
            return;
        end
        pend_op = op; pend_addr = addr; pend_wdata = wd; pend_err = 1'b0; pend_id = m_id;
        case (op)
            2'b00: begin pend_rdata = shadow[addr]; pend_beats = 1; lat = 2 + S + R; end
            2'b01: begin shadow[addr] = wd; pend_rdata = m_rdata; pend_beats = 1; lat = 2 + S + R; end
            2'b10: begin
                idv = tie0 ? 4'h0 : resp_id;
                pend_id = idv; pend_rdata = {4'h0, idv}; pend_err = (idv != EXP_ID);
                pend_beats = 5; lat = 5 * (1 + S + R) + 1;
            end
            default: begin pend_rdata = m_rdata; pend_err = 1'b1; pend_beats = 0; lat = 1; end
        endcase
        // lat counts edges from accept to the edge that samples RSP_VALID high.
        pend_due = acc + lat - 1;
        pend = 1'b1;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 200 && pend; k++) begin
            @(posedge clk); #1;
        end
        if (pend) begin
            chk("response timeout", 0, 1);
            pend = 1'b0;
        end
    endtask

    task automatic rise_delay(output int lat);
        lat = 0;
        for (int k = 0; k < 100 && !o_rsp_valid; k++) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic poke(input logic [3:0] a, input logic [7:0] v);
        rmem[a] = v; shadow[a] = v;
    endtask

    initial begin
        int lat;
        logic [1:0] op;
        logic [3:0] addr;
        for (int i = 0; i < 16; i++) poke(4'(i), 8'($urandom));
        repeat (3) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle ready after reset", o_cmd_ready, 1);
        chk("idle cs after reset", o_cs, 1);

        // Read of the interrupt-enable register.
        poke(4'h2, 8'h80);
        issue(2'b00, 4'h2, 8'h00);
        rise_delay(lat);
        chk("read rsp_valid rise delay", lat, 4);
        wait_done();
        chk("read intena data", o_rsp_rdata, 8'h80);

        // Write clears intchg.
        poke(4'h1, 8'h80);
        issue(2'b01, 4'h1, 8'h00);
        wait_done();
        chk("responder intchg after write", rmem[1], 8'h00);

        // ID probe twice.
        for (int r = 0; r < 2; r++) begin
            issue(2'b10, 4'h0, 8'h00);
            rise_delay(lat);
            chk("probe rsp sampling edge", lat + 1, 21);
            wait_done();
            chk("probe id_val literal", o_id_val, 4'hd);
            chk("probe id_ok literal", o_id_ok, 1);
            chk("probe rdata literal", o_rsp_rdata, 8'h0d);
        end

        // Probe against a silent bus, then a reserved op.
        tie0 = 1'b1;
        issue(2'b10, 4'h0, 8'h00);
        wait_done();
        chk("silent probe id_val", o_id_val, 4'h0);
        chk("silent probe id_ok", o_id_ok, 0);
        tie0 = 1'b0;
        issue(2'b11, 4'h5, 8'h00);
        rise_delay(lat);
        chk("reserved rsp_valid rise delay", lat, 0);
        chk("reserved rsp_err", o_rsp_err, 1);
        wait_done();

        // Reset in the second strobe cycle.
        issue(2'b00, 4'h2, 8'h00);
        @(posedge clk); @(posedge clk); #2;
        chk("ds low before reset", o_ds, 0);
        rst_n = 1'b0;
        #1;
        chk("cs high at reset", o_cs, 1);
        chk("ds high at reset", o_ds, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(2'b00, 4'h5, 8'h00);
        wait_done();
        issue(2'b01, 4'h6, 8'h3c);
        wait_done();

        // Random traffic.
        for (int n = 0; n < 80; n++) begin
            op   = 2'($urandom_range(0, 9) < 4 ? 0 : ($urandom_range(0, 5) < 3 ? 1 : ($urandom_range(0, 1) == 0 ? 2 : 3)));
            addr = 4'($urandom);
            if (addr == 4'h9) addr = 4'h8;
            if (op == 2'b10) begin
                resp_id = 4'($urandom);
                if ($urandom_range(0, 1) == 0) resp_id = EXP_ID;
                tie0 = ($urandom_range(0, 3) == 0);
            end
            issue(op, addr, 8'($urandom));
            wait_done();
            tie0 = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
